freq_meter: RTL and testbench
=============================

Name: freq_meter

Overview:
- Gated frequency counter; measures an external or divided clock-like signal against the 50 MHz system clock.
- It is the measuring end of the clock-divider chain: it reads a tap (or any pin), counts rising edges over a fixed gate window, and reports edges per window.
- Sits beside the divider on the Nexys2 clock design; result drives display/debug logic.

Parameters:
- GATE_CYCLES, 50000000, gate window length in clk cycles (1 s at 50 MHz); must be >= 2.
- CNT_W, 32, width of edge counter and result.
- GATE_W, 32, width of gate-window down-counter; must hold GATE_CYCLES-1.

Ports:
- clk  input  1  system clock, 50 MHz.
- RESETn  input  1  asynchronous, active-high reset.
- sig_in  input  1  signal to measure; asynchronous to clk.
- start  input  1  single-cycle request to begin one measurement; sampled only in IDLE.
- freq_out  output  CNT_W  rising edges counted in last completed window; held until the next result.
- valid  output  1  one-cycle pulse when freq_out updates.
- busy  output  1  high while a measurement is in progress (state != IDLE).
- overflow  output  1  edge count saturated during last window; updates with valid.

Behaviour:
- Reset: RESETn, asynchronous and active-high, clock clk. While RESETn=1, all registers clear: state=IDLE, freq_out=0, valid=0, busy=0, overflow=0, synchronizer flops=0, counters=0. Reset mid-window aborts the window; no valid is produced.
- Input path: 2-FF synchronizer, then a third flop; edge pulse = sync2 & ~sync3. Edge-pulse latency from sig_in rising edge is 2-3 clk. Max measurable frequency is below clk/2 (sig_in high and low each >= 1 clk).
- FSM states:
  - IDLE: busy=0. When start=1, load gate_cnt=GATE_CYCLES-1, clear edge_cnt and ovf flag, and go to GATE.
  - GATE: busy=1, lasting exactly GATE_CYCLES cycles. Each cycle with edge pulse=1 increments edge_cnt. gate_cnt decrements; when gate_cnt=0 (last gate cycle, edge still counted), go to DONE.
  - DONE: one cycle, busy=1. freq_out<=edge_cnt, overflow<=ovf flag, valid<=1, then go to IDLE.
- valid is registered: high the cycle after DONE, for exactly 1 cycle.
- Saturation: if edge_cnt = 2^CNT_W-1 and an edge pulse arrives, edge_cnt holds and the ovf flag sets. No wrap-around.
- start outside IDLE is ignored; it is not queued. start in the same cycle DONE returns to IDLE is also ignored.
- Counting window is defined on edge pulses, not raw sig_in. Edges detected before GATE or during DONE are not counted.
- Arithmetic is unsigned. freq_out in Hz equals the edge count when GATE_CYCLES = clk frequency.

Optional Feature:
- Macro FREQ_METER_CONT_EN.
- Defined: continuous mode. DONE goes directly to GATE, reloading gate_cnt and clearing edge_cnt/ovf, so windows repeat back-to-back with a 1-cycle DONE gap. The first window still requires start. busy stays 1 after the first start until reset. valid pulses once per window.
- Not defined: single-shot as above, returning to IDLE after each result.

Test Plan:
- Reset: assert RESETn mid-GATE with sig_in toggling -> freq_out=0, valid=0, busy=0, overflow=0 immediately (asynchronous). After release, state=IDLE, no valid without start.
- Basic count: GATE_CYCLES=1000, sig_in period 20 clk (50% duty), start pulse -> busy for 1001 cycles, a single valid pulse, freq_out=50, overflow=0.
- Phase independence: repeat with sig_in phase offsets of 0..19 clk relative to start -> freq_out=50 every time.
- Saturation: CNT_W=4, GATE_CYCLES=100, sig_in period 4 clk -> freq_out=15, overflow=1. A following run with sig_in period 20 -> freq_out=5, overflow=0.
- Start handling: start pulses during GATE and in the DONE cycle -> ignored; exactly one valid. sig_in held constant -> freq_out=0.
- FREQ_METER_CONT_EN defined: GATE_CYCLES=1000, period 20, one start -> valid every 1001 cycles with freq_out=50 each time, busy held at 1.

Source files
------------

// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
//
// Gated frequency counter. Counts the rising edges of an asynchronous input
// (typically a divider tap) over a fixed window of GATE_CYCLES system clocks.
// It then publishes the count as edges per window. With GATE_CYCLES equal to
// the clk frequency, the result reads directly in Hz.
//
// Parameters:
//   GATE_CYCLES : gate window length in clk cycles (>= 2)
//   CNT_W       : width of the edge counter and of freq_out
//   GATE_W      : width of the gate down-counter (must hold GATE_CYCLES-1)
//
// Ports:
//   clk      in   system clock (50 MHz)
//   RESETn   in   asynchronous reset, active HIGH despite the name
//   sig_in   in   signal to measure, asynchronous to clk
//   start    in   one-cycle request to begin a measurement (honoured in IDLE)
//   freq_out out  edges counted in the last completed window, held
//   valid    out  one-cycle pulse when freq_out/overflow update
//   busy     out  high while a measurement is in progress
//   overflow out  edge counter saturated during the last window
//
// Build option:
//   FREQ_METER_CONT_EN - continuous mode. After the first start, windows
//   repeat back-to-back with a one-cycle DONE gap between them, and busy
//   stays high until reset. Without the macro, each start yields exactly
//   one result and the meter returns to IDLE.
// -----------------------------------------------------------------------------
module freq_meter #(
    parameter int unsigned GATE_CYCLES = 32'd50000000,
    parameter int unsigned CNT_W       = 32'd32,
    parameter int unsigned GATE_W      = 32'd32
) (
    input  logic             clk,
    input  logic             RESETn,
    input  logic             sig_in,
    input  logic             start,
    output logic [CNT_W-1:0] freq_out,
    output logic             valid,
    output logic             busy,
    output logic             overflow
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 32'd1);
    localparam logic [GATE_W-1:0] GATE_ZERO = {GATE_W{1'b0}};
    localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    // Input synchronizer plus one delay stage for edge detection.
    logic              r_sync1;
    logic              r_sync2;
    logic              r_sync3;

    // Sequencer state and measurement counters.
    state_t            r_state;
    logic [GATE_W-1:0] r_gate_cnt;
    logic [CNT_W-1:0]  r_edge_cnt;
    logic              r_ovf;

    // Registered outputs.
    logic [CNT_W-1:0]  r_freq;
    logic              r_valid;
    logic              r_busy;
    logic              r_overflow;

    logic              w_edge;
    logic              w_gate_last;
    logic              w_cnt_full;

    // Single-cycle pulse for each synchronized rising edge of sig_in.
    assign w_edge      = r_sync2 & ~r_sync3;
    // The cycle with gate_cnt at zero is the last cycle of the window. An edge
    // in that cycle is still counted.
    assign w_gate_last = (r_gate_cnt == GATE_ZERO);
    // Once the counter is full, further edges only raise the overflow flag.
    assign w_cnt_full  = (r_edge_cnt == CNT_MAX);

    assign freq_out = r_freq;
    assign valid    = r_valid;
    assign busy     = r_busy;
    assign overflow = r_overflow;

    // Bring sig_in into the clk domain and keep one extra stage for edge detection.
    always_ff @(posedge clk or posedge RESETn) begin
        if (RESETn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= sig_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    // Measurement sequencer: arm on start, count edges through the gate, publish the result.
    always_ff @(posedge clk or posedge RESETn) begin
        if (RESETn) begin
            r_state    <= ST_IDLE;
            r_gate_cnt <= GATE_ZERO;
            r_edge_cnt <= CNT_ZERO;
            r_ovf      <= 1'b0;
            r_freq     <= CNT_ZERO;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state    <= ST_GATE;
                        r_busy     <= 1'b1;
                        r_gate_cnt <= GATE_LOAD;
                        r_edge_cnt <= CNT_ZERO;
                        r_ovf      <= 1'b0;
                    end else begin
                        r_state    <= ST_IDLE;
                        r_busy     <= 1'b0;
                    end
                end
                ST_GATE: begin
                    if (w_edge) begin
                        if (w_cnt_full) begin
                            r_ovf      <= 1'b1;
                        end else begin
                            r_edge_cnt <= r_edge_cnt + CNT_ONE;
                        end
                    end
                    if (w_gate_last) begin
                        r_state    <= ST_DONE;
                    end else begin
                        r_gate_cnt <= r_gate_cnt - GATE_ONE;
                    end
                end
                ST_DONE: begin
                    r_freq     <= r_edge_cnt;
                    r_overflow <= r_ovf;
                    r_valid    <= 1'b1;
`ifdef FREQ_METER_CONT_EN
                    // Re-arm immediately. The DONE cycle is the only gap
                    // between windows, and edges seen in it are not counted.
                    r_state    <= ST_GATE;
                    r_gate_cnt <= GATE_LOAD;
                    r_edge_cnt <= CNT_ZERO;
                    r_ovf      <= 1'b0;
`else
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
`endif
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// -----------------------------------------------------------------------------
// tb_freq_meter
//
// Drives two meters from one clock:
//   DUT0: GATE=1000, CNT_W=32
//   DUT1: GATE=100,  CNT_W=4 (saturation)
//
// Each meter runs a table of measurements: directed cases plus random ones.
// Expected results come from a recorded history of sig_in rising edges. The
// edges are counted against the gate window that the start sample implies.
// -----------------------------------------------------------------------------
module tb_freq_meter;

    localparam int G0     = 1000;
    localparam int G1     = 100;
    localparam int R_LEAD = 0;
    localparam int R_RUN  = 1;
    localparam int R_TAIL = 2;
    localparam int R_IDLE = 3;
    // A sig_in value applied before posedge t is counted iff that posedge's
    // edge pulse lands in gate cycles s+1..s+G, i.e. t in [s-1, s+G-2].
    localparam int SYNC_LAT = 2;

    typedef struct {
        int p;       // period; 0 = constant level h, -1 = random bits
        int h;       // high cycles per period
        int j;       // phase offset relative to the start sample
        bit extra;   // pulse start again during GATE and in DONE
        int plan_f;  // directed freq_out expectation, -1 = none
        int plan_o;  // directed overflow expectation, -1 = none
    } run_t;

    logic        clk    = 1'b0;
    logic        RESETn = 1'b1;
    logic        sig0   = 1'b0;
    logic        sig1   = 1'b0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [31:0] freq0;
    logic [3:0]  freq1;
    logic        valid0, valid1, busy0, busy1, ovf0, ovf1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    run_t        runs [2][32];
    int          n_runs [2];
    int          gcyc [2];
    longint      maxv [2];
    int          win_s [2];
    int          t0 [2];
    int          tail_end [2];
    int          cur [2];
    int          rstate [2];
    bit          started [2];
    logic        last_sig [2];
    logic [31:0] hold_f [2];
    logic        hold_o [2];
    int          rise_q0 [$];
    int          rise_q1 [$];

    freq_meter #(.GATE_CYCLES(G0), .CNT_W(32), .GATE_W(16)) u_dut0 (
        .clk(clk), .RESETn(RESETn), .sig_in(sig0), .start(start0),
        .freq_out(freq0), .valid(valid0), .busy(busy0), .overflow(ovf0)
    );

    freq_meter #(.GATE_CYCLES(G1), .CNT_W(4), .GATE_W(8)) u_dut1 (
        .clk(clk), .RESETn(RESETn), .sig_in(sig1), .start(start1),
        .freq_out(freq1), .valid(valid1), .busy(busy1), .overflow(ovf1)
    );

    // 100 MHz-style bench clock; absolute frequency is irrelevant here.
    always #5 clk = ~clk;

    // Posedge index; at a negedge, cyc is the index of the preceding posedge.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void add_run(int i, int p, int h, int j, bit extra, int pf, int po);
        runs[i][n_runs[i]] = '{p: p, h: h, j: j, extra: extra, plan_f: pf, plan_o: po};
        n_runs[i]++;
    endfunction

    function automatic int count_rises(int i, int lo, int hi);
        int n;
        n = 0;
        if (i == 0) begin
            foreach (rise_q0[k]) if (rise_q0[k] >= lo && rise_q0[k] <= hi) n++;
        end else begin
            foreach (rise_q1[k]) if (rise_q1[k] >= lo && rise_q1[k] <= hi) n++;
        end
        return n;
    endfunction

    function automatic logic pattern(int i, int t);
        run_t r;
        int   ph;
        r = runs[i][cur[i]];
        if (r.p == 0) return (r.h != 0);
        if (r.p < 0) return ($urandom_range(0, 1) != 0);
        ph = (t - t0[i] + r.j) % r.p;
        if (ph < 0) ph += r.p;
        return (ph < r.h);
    endfunction

    task automatic setup_run(input int i, input int t);
        t0[i]     = t + int'($urandom_range(25, 60));
        rstate[i] = R_LEAD;
    endtask

    // One clock of stimulus and checking for both meters, done at the negedge.
    task automatic step_cycle();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            logic [31:0] o_f;
            logic        o_v, o_b, o_o, exp_v, exp_b, s, st;
            int          k, t, cnt;
            k  = cyc;
            t  = cyc + 1;
            st = 1'b0;
            if (i == 0) begin
                o_f = freq0; o_v = valid0; o_b = busy0; o_o = ovf0;
            end else begin
                o_f = {28'd0, freq1}; o_v = valid1; o_b = busy1; o_o = ovf1;
            end

            exp_v = (win_s[i] >= 0) && (k == win_s[i] + gcyc[i] + 1);
`ifdef FREQ_METER_CONT_EN
            exp_b = started[i];
`else
            exp_b = (win_s[i] >= 0) && (k >= win_s[i]) && (k <= win_s[i] + gcyc[i]);
`endif
            check_eq($sformatf("busy%0d", i), o_b, exp_b);
            check_eq($sformatf("valid%0d", i), o_v, exp_v);
            if (exp_v) begin
                cnt = count_rises(i, win_s[i] - 1, win_s[i] + gcyc[i] - SYNC_LAT);
                if (longint'(cnt) > maxv[i]) begin
                    hold_f[i] = maxv[i][31:0];
                    hold_o[i] = 1'b1;
                end else begin
                    hold_f[i] = 32'(cnt);
                    hold_o[i] = 1'b0;
                end
                check_eq($sformatf("freq%0d", i), o_f, hold_f[i]);
                check_eq($sformatf("ovf%0d", i), o_o, hold_o[i]);
                if (runs[i][cur[i]].plan_f >= 0)
                    check_eq($sformatf("plan_freq%0d", i), o_f, 32'(runs[i][cur[i]].plan_f));
                if (runs[i][cur[i]].plan_o >= 0)
                    check_eq($sformatf("plan_ovf%0d", i), o_o, 32'(runs[i][cur[i]].plan_o));
`ifdef FREQ_METER_CONT_EN
                win_s[i] = k;
`endif
            end

            case (rstate[i])
                R_LEAD: begin
                    if (t == t0[i]) begin
                        st        = 1'b1;
                        rstate[i] = R_RUN;
                    end
                end
                R_RUN: begin
                    if (runs[i][cur[i]].extra &&
                        (t == t0[i] + gcyc[i] / 2 || t == t0[i] + gcyc[i] + 1)) st = 1'b1;
`ifndef FREQ_METER_CONT_EN
                    if (k == t0[i] + gcyc[i] + 1) begin
                        rstate[i]   = R_TAIL;
                        tail_end[i] = k + 8;
                    end
`endif
                end
                R_TAIL: begin
                    if (k >= tail_end[i]) begin
                        check_eq($sformatf("hold_freq%0d", i), o_f, hold_f[i]);
                        check_eq($sformatf("hold_ovf%0d", i), o_o, hold_o[i]);
                        cur[i]++;
                        if (cur[i] >= n_runs[i]) rstate[i] = R_IDLE;
                        else setup_run(i, t);
                    end
                end
                default: ;
            endcase

            // A start is honoured only if the meter is idle at that sample.
            if (st) begin
`ifdef FREQ_METER_CONT_EN
                if (!started[i]) begin
                    started[i] = 1'b1;
                    win_s[i]   = t;
                end
`else
                if (win_s[i] < 0 || t >= win_s[i] + gcyc[i] + 2) win_s[i] = t;
`endif
            end

            s = (rstate[i] == R_IDLE) ? 1'b0 : pattern(i, t);
            if (s && !last_sig[i]) begin
                if (i == 0) rise_q0.push_back(t);
                else rise_q1.push_back(t);
            end
            last_sig[i] = s;
            if (i == 0) begin
                sig0 = s; start0 = st;
            end else begin
                sig1 = s; start1 = st;
            end
        end
    endtask

    initial begin
        int limit;
        int p;
        gcyc[0] = G0;
        gcyc[1] = G1;
        maxv[0] = 64'hFFFF_FFFF;
        maxv[1] = 64'd15;
        for (int i = 0; i < 2; i++) begin
            n_runs[i] = 0; win_s[i] = -1; cur[i] = 0; started[i] = 1'b0;
            last_sig[i] = 1'b0; hold_f[i] = 32'd0; hold_o[i] = 1'b0;
        end

        // DUT0: phase sweep at period 20, start abuse, constant inputs, random.
        for (int j = 0; j < 20; j++) add_run(0, 20, 10, j, 1'b0, 50, 0);
        add_run(0, 20, 10, 7, 1'b1, 50, 0);
        add_run(0, 0, 0, 0, 1'b1, 0, 0);
        add_run(0, 0, 1, 0, 1'b0, 0, 0);
        add_run(0, -1, 0, 0, 1'b0, -1, -1);
        for (int n = 0; n < 6; n++) begin
            p = int'($urandom_range(2, 60));
            add_run(0, p, int'($urandom_range(1, p - 1)), int'($urandom_range(0, p - 1)),
                    1'($urandom_range(0, 1)), -1, -1);
        end
        // DUT1: saturation, recovery, constant level, random.
        add_run(1, 4, 2, 0, 1'b0, 15, 1);
        add_run(1, 20, 10, 0, 1'b0, 5, 0);
        add_run(1, 0, 1, 0, 1'b1, 0, 0);
        add_run(1, -1, 0, 0, 1'b1, -1, -1);
        for (int n = 0; n < 10; n++) begin
            p = int'($urandom_range(2, 30));
            add_run(1, p, int'($urandom_range(1, p - 1)), int'($urandom_range(0, p - 1)),
                    1'($urandom_range(0, 1)), -1, -1);
        end
`ifdef FREQ_METER_CONT_EN
        runs[0][0].extra = 1'b1;
        runs[1][0].extra = 1'b1;
`endif

        // Power-on reset: all outputs must be clear.
        repeat (3) @(negedge clk);
        check_eq("rst_freq0", freq0, 32'd0);
        check_eq("rst_valid0", valid0, 1'b0);
        check_eq("rst_busy0", busy0, 1'b0);
        check_eq("rst_ovf0", ovf0, 1'b0);
        check_eq("rst_freq1", {28'd0, freq1}, 32'd0);
        check_eq("rst_valid1", valid1, 1'b0);
        check_eq("rst_busy1", busy1, 1'b0);
        check_eq("rst_ovf1", ovf1, 1'b0);
        RESETn = 1'b0;

        setup_run(0, cyc + 1);
        setup_run(1, cyc + 1);
`ifdef FREQ_METER_CONT_EN
        limit = cyc + 6000;
`else
        limit = cyc + 80000;
`endif
        while (!(rstate[0] == R_IDLE && rstate[1] == R_IDLE) && cyc < limit) step_cycle();
`ifndef FREQ_METER_CONT_EN
        check_eq("all_runs_done", (rstate[0] == R_IDLE && rstate[1] == R_IDLE), 1'b1);
`endif

        // Reset in the middle of a gate window with sig_in toggling.
        @(negedge clk);
        start0 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            sig0 = ~sig0;
            sig1 = ~sig1;
        end
        check_eq("busy_pre_rst0", busy0, 1'b1);
        check_eq("busy_pre_rst1", busy1, 1'b1);
`ifndef FREQ_METER_CONT_EN
        check_eq("freq_pre_rst0", freq0, hold_f[0]);
        check_eq("freq_pre_rst1", {28'd0, freq1}, hold_f[1]);
`endif
        #3 RESETn = 1'b1;
        #1;
        check_eq("arst_freq0", freq0, 32'd0);
        check_eq("arst_valid0", valid0, 1'b0);
        check_eq("arst_busy0", busy0, 1'b0);
        check_eq("arst_ovf0", ovf0, 1'b0);
        check_eq("arst_freq1", {28'd0, freq1}, 32'd0);
        check_eq("arst_valid1", valid1, 1'b0);
        check_eq("arst_busy1", busy1, 1'b0);
        check_eq("arst_ovf1", ovf1, 1'b0);
        repeat (3) @(negedge clk);
        RESETn = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            sig0 = ~sig0;
            sig1 = ~sig1;
            check_eq("post_rst_valid0", valid0, 1'b0);
            check_eq("post_rst_busy0", busy0, 1'b0);
            check_eq("post_rst_valid1", valid1, 1'b0);
            check_eq("post_rst_busy1", busy1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
